// File: rtl/fc_pkg.sv
// Shared constants and types for the pool->FC feature-map read path.
package fc_pkg;

    localparam int FC_LANES    = 8;
    localparam int FC_DATA_W   = 8;
    localparam int FC_FM_BYTES = 384;

    // Read-master sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fc_state_e;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int fc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_fm_skid.sv
// Two-entry first-word-fall-through FIFO with a registered head.
// The head register drives the stream directly, so dout is stable until popped.
// Push and pop in the same cycle are accepted at any occupancy, including full.
module fc_fm_skid
    import fc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         empty
);

    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic [1:0]   count_r;

    // Head/tail storage and occupancy update for every push/pop combination
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push) begin
                        head_r  <= din;
                        count_r <= 2'd1;
                    end else begin
                        count_r <= 2'd0;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_r <= din;
                    end else if (push) begin
                        tail_r  <= din;
                        count_r <= 2'd2;
                    end else if (pop) begin
                        count_r <= 2'd0;
                    end else begin
                        count_r <= 2'd1;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_r <= tail_r;
                        if (push) begin
                            tail_r <= din;
                        end else begin
                            count_r <= 2'd1;
                        end
                    end else begin
                        count_r <= 2'd2;
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

    assign dout  = head_r;
    assign count = count_r;
    assign empty = (count_r == 2'd0);

endmodule

// File: rtl/fc_fm_reader.sv
// Read-side master for the pool->FC feature-map buffer.
// On a start pulse it sweeps the buffer word by word (optionally several passes)
// and forwards each returned word, tagged with last/pass, into a valid/ready stream.
// Reads are throttled so FIFO occupancy plus the word in flight never exceeds two.
module fc_fm_reader
    import fc_pkg::*;
#(
    parameter int DATA_W   = FC_DATA_W,
    parameter int LANES    = FC_LANES,
    parameter int FM_BYTES = FC_FM_BYTES,
    parameter int ADDR_W   = 16,
    parameter int PASSES   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_fc_start,
    output logic [ADDR_W-1:0]            o_fc_fm_addr,
    input  logic [DATA_W*LANES-1:0]      i_fc_fm_data,
    output logic [DATA_W*LANES-1:0]      o_fm_data,
    output logic                         o_fm_valid,
    input  logic                         i_fm_ready,
    output logic                         o_fm_last,
    output logic [$clog2(PASSES+1)-1:0]  o_fm_pass,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int NWORDS = FM_BYTES / LANES;
    localparam int IDX_W  = fc_width(NWORDS);
    localparam int PASS_W = $clog2(PASSES + 1);
    localparam int DW     = DATA_W * LANES;
    localparam int EW     = DW + 1 + PASS_W;

    fc_state_e         state_r;
    logic [IDX_W-1:0]  word_idx_r;
    logic [PASS_W-1:0] pass_r;
    logic              inflight_r;
    logic              tag_last_r;
    logic [PASS_W-1:0] tag_pass_r;
    logic              busy_r;
    logic              done_r;

    logic [EW-1:0]     fifo_din_s;
    logic [EW-1:0]     fifo_dout_s;
    logic [1:0]        fifo_count_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic [2:0]        occ_s;
    logic              issue_s;
    logic              idx_last_s;
    logic              pass_last_s;
    logic              fin_pop_s;

    assign pop_s       = ~fifo_empty_s & i_fm_ready;
    assign idx_last_s  = (word_idx_r == IDX_W'(NWORDS - 1));
    assign pass_last_s = (pass_r == PASS_W'(PASSES - 1));

    // Issue throttle: occupancy after this cycle's push/pop must leave room for one more read
    always_comb begin
        occ_s   = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s = 1'b0;
        if ((state_r == ST_FETCH) && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Final pop: last word of the last pass leaving an otherwise empty pipeline
    assign fin_pop_s = pop_s && fifo_dout_s[DW]
                       && (fifo_dout_s[DW+1 +: PASS_W] == PASS_W'(PASSES - 1))
                       && (fifo_count_s == 2'd1) && !inflight_r;

    // FSM, word/pass counters, in-flight tag and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            word_idx_r <= '0;
            pass_r     <= '0;
            inflight_r <= 1'b0;
            tag_last_r <= 1'b0;
            tag_pass_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                tag_last_r <= idx_last_s;
                tag_pass_r <= pass_r;
                if (idx_last_s) begin
                    word_idx_r <= '0;
                    pass_r     <= pass_r + PASS_W'(1);
                end else begin
                    word_idx_r <= word_idx_r + IDX_W'(1);
                end
            end else begin
                word_idx_r <= word_idx_r;
            end
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (i_fc_start) begin
                        state_r    <= ST_FETCH;
                        word_idx_r <= '0;
                        pass_r     <= '0;
                        busy_r     <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (issue_s && idx_last_s && pass_last_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (fin_pop_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_din_s = {tag_pass_r, tag_last_r, i_fc_fm_data};

    fc_fm_skid #(.W(EW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_r),
        .din   (fifo_din_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign o_fc_fm_addr = ADDR_W'(int'(word_idx_r) * LANES);
    assign o_fm_data    = fifo_dout_s[DW-1:0];
    assign o_fm_last    = fifo_dout_s[DW];
    assign o_fm_pass    = fifo_dout_s[DW+1 +: PASS_W];
    assign o_fm_valid   = ~fifo_empty_s;
    assign o_busy       = busy_r;
    assign o_done       = done_r;

endmodule
